// File: rtl/encryption_engine.sv
// Iterative 8-bit block encryptor: accepts a plaintext byte and key, runs ROUNDS key-mixed
// rounds (one per clock), then holds the ciphertext on a valid/ready output until consumed.
module encryption_engine #(
  parameter int N      = 8,
  parameter int ROUNDS = 4,
  parameter int ROT    = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] e_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t       state;
  logic [N-1:0] s;
  logic [N-1:0] k;
  logic [3:0]   r;
  logic [N-1:0] nxt;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int a);
    logic [2*N-1:0] d;
    d = {x, x} << (a % N);
    return d[2*N-1:N];
  endfunction

  // Round key is the key rotated by the round index, salted with the round number.
  function automatic logic [N-1:0] round_fn(input logic [N-1:0] sv, input logic [N-1:0] kv,
                                            input logic [3:0] rv);
    logic [N-1:0] rk;
    rk = rotl(kv, int'(rv)) ^ N'(int'(rv) + 1);
    return rotl(sv ^ rk, ROT) + rk;
  endfunction

  assign nxt = round_fn(s, k, r);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      e_data    <= '0;
      r         <= '0;
      s         <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s        <= in_data;
            k        <= key;
            r        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s <= nxt;
          r <= r + 4'd1;
          if (r == LAST) begin
            e_data    <= nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // out_ready only counts once out_valid is already visible, i.e. from this state.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encryption_engine.sv
// Bench for encryption_engine: transaction-level reference model checked every cycle,
// plus directed vectors, backpressure, ignored-input, reset and round-trip checks.
module tb_encryption_engine;

  localparam int N = 8;
  localparam int ROUNDS = 4;
  localparam int ROT = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] e_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int busy_cnt = 0;

  // Model: 0 = waiting for input, 1 = computing, 2 = result held
  int m_mode = 0;
  int m_left = 0;
  int m_res = 0;
  int m_edata = 0;

  encryption_engine #(.N(N), .ROUNDS(ROUNDS), .ROT(ROT)) dut (
    .clock(clock), .reset_n(reset_n), .key(key), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .e_data(e_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic int rotl8(int x, int a);
    int aa;
    aa = a % 8;
    x = x & 255;
    return ((x << aa) | (x >> (8 - aa))) & 255;
  endfunction

  function automatic int rk_of(int k, int r);
    return rotl8(k, r % 8) ^ ((r + 1) & 255);
  endfunction

  function automatic int encrypt(int d, int k);
    int s;
    s = d & 255;
    for (int r = 0; r < ROUNDS; r++)
      s = (rotl8(s ^ rk_of(k, r), ROT) + rk_of(k, r)) & 255;
    return s;
  endfunction

  function automatic int decrypt(int c, int k);
    int s;
    s = c & 255;
    for (int r = ROUNDS - 1; r >= 0; r--) begin
      s = (s - rk_of(k, r)) & 255;
      s = rotl8(s, 8 - ROT);
      s = s ^ rk_of(k, r);
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edges the DUT samples.
  always @(posedge clock) begin
    if (!reset_n) begin
      m_mode = 0;
      m_edata = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
             m_res = encrypt(int'(in_data), int'(key));
             m_left = ROUNDS;
             m_mode = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_edata = m_res;
               m_mode = 2;
             end
           end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    busy_cnt += int'(busy);
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(m_mode == 0));
      chk("busy", int'(busy), int'(m_mode == 1));
      chk("out_valid", int'(out_valid), int'(m_mode == 2));
      chk("e_data", int'(e_data), m_edata);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int d, input int k);
    bit ok;
    ok = 1'b0;
    step();
    in_valid = 1'b1;
    in_data = N'(d);
    key = N'(k);
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      step();
      lat++;
    end
    chk("out_timeout", int'(out_valid), 1);
  endtask

  int lat;
  int v0;
  int d;
  int k;
  int seen;

  initial begin
    // Pin the model itself against hand-computed vectors
    chk("model_vec1", encrypt(8'h01, 8'h00), 8'h82);
    chk("model_vec2", encrypt(8'h4F, 8'h0F), 8'hD5);
    chk("model_inverse", decrypt(8'hD5, 8'h0F), 8'h4F);

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_e_data", int'(e_data), 0);

    // Basic vector, out_ready held high
    out_ready = 1'b1;
    busy_cnt = 0;
    send(8'h01, 8'h00);
    wait_out(lat);
    chk("basic_latency", lat, 4);
    chk("basic_data", int'(e_data), 8'h82);
    repeat (3) step();
    chk("basic_busy_cycles", busy_cnt, 4);
    chk("basic_idle_after", int'(in_ready), 1);

    // Second vector; key changes during RUN must not matter
    send(8'h4F, 8'h0F);
    key = 8'hA0;
    in_data = 8'h00;
    wait_out(lat);
    chk("vec2_data", int'(e_data), 8'hD5);
    repeat (3) step();

    // Backpressure
    out_ready = 1'b0;
    send(8'h5A, 8'h3C);
    wait_out(lat);
    v0 = int'(e_data);
    chk("bp_value", v0, encrypt(8'h5A, 8'h3C));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {23'd0, in_ready, out_valid, e_data}, {23'd0, 1'b0, 1'b1, 8'(v0)});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ov", int'(out_valid), 0);
    chk("bp_release_ir", int'(in_ready), 1);
    chk("bp_keep_data", int'(e_data), v0);

    // Ignored in_valid during RUN and DONE
    send(8'h11, 8'h22);
    in_valid = 1'b1;
    in_data = 8'h99;
    key = 8'h77;
    step();
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("ign_run_data", int'(e_data), encrypt(8'h11, 8'h22));
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("ign_done_data", int'(e_data), encrypt(8'h11, 8'h22));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen += int'(out_valid) + int'(busy);
    end
    chk("ign_no_second", seen, 0);

    // Reset mid-RUN discards the byte in flight
    out_ready = 1'b1;
    send(8'h33, 8'h55);
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_e_data", int'(e_data), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen += int'(out_valid);
    end
    chk("midrst_no_result", seen, 0);

    // Round trip through the inverse schedule
    for (int i = 0; i < 256; i++) begin
      d = int'($urandom_range(0, 255));
      k = int'($urandom_range(0, 255));
      send(d, k);
      wait_out(lat);
      chk("roundtrip", decrypt(int'(e_data), k), d);
      step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encryption_engine.md
Name: encryption_engine

Overview:
- Iterative multi-round 8-bit block encryptor; transmit-side counterpart of the decryption block.
- Accepts one plaintext byte plus key through a valid/ready handshake.
- Applies ROUNDS key-mixed rounds, one per clock.
- Holds the ciphertext on a valid/ready output until it is consumed. Sits between the plaintext source and the link/storage feeding the decryption block.

Parameters:
- N, 8, data and key width in bits.
- ROUNDS, 4, number of rounds; legal range 1..15.
- ROT, 3, left-rotate amount per round; legal range 1..N-1.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- key  input  N  cipher key; sampled only on the accept edge.
- in_data  input  N  plaintext byte; sampled only on the accept edge.
- in_valid  input  1  in_data and key are valid.
- in_ready  output  1  engine can accept a new byte.
- e_data  output  N  ciphertext byte.
- out_valid  output  1  e_data is valid.
- out_ready  input  1  downstream consumes e_data.
- busy  output  1  high while rounds are in progress (RUN state).

Behaviour:
- Reset is sampled only at a rising clock edge with reset_n=0. It overrides all other inputs, including mid-RUN and mid-DONE, and any in-flight byte is discarded.
- Values after reset: state=IDLE, in_ready=1, out_valid=0, busy=0, e_data=0, round counter=0, internal state and key registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: s<=in_data, k<=key, r<=0, state goes to RUN.
- RUN:
  - in_ready=0, busy=1, one round per edge.
  - Round r: rk = rotl(k, r mod N) XOR (r+1) truncated to N bits. Then s <= rotl(s XOR rk, ROT) + rk, modulo 2^N with the carry discarded.
  - r increments each round. On the edge applying round ROUNDS-1, the result loads into e_data, out_valid<=1, and state goes to DONE.
- DONE:
  - out_valid=1 and e_data stay stable until an edge with out_ready=1.
  - On that edge: out_valid<=0 and state goes to IDLE. e_data keeps its last value.
  - in_ready=0 in DONE, so no overlap and no back-to-back accept in the same cycle.
- Latency: an accept at edge t gives out_valid=1 after edge t+ROUNDS. With out_ready held at 1, the next accept is possible at edge t+ROUNDS+2.
- in_ready, busy and out_valid are registered state decodes with no combinational path from inputs.
- Changes to key or in_data outside the accept edge have no effect on the byte in flight.
- in_valid while not IDLE is ignored, with no queuing. The source must hold in_valid until in_ready.
- out_ready while not in DONE is ignored.
- Asserting out_ready in the same edge that enters DONE does not consume the result. Consumption needs out_valid=1 already visible.
- The decryption block inverts each round in reverse order, applying subtract rk, then rotr ROT, then XOR rk, for r=ROUNDS-1 down to 0, using the same schedule.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles mid-RUN after an accept -> in_ready=1, out_valid=0, busy=0, e_data=0. No result appears afterwards.
- Basic vector: key=8'h00, in_data=8'h01, out_ready=1 -> out_valid rises exactly 4 edges after accept, with e_data=8'h82. busy is high for 4 cycles.
- Second vector: key=8'h0F, in_data=8'h4F (79) -> e_data=8'hD5. Changing key to 8'hA0 during RUN leaves the result at 8'hD5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> e_data stays stable and in_ready stays 0. Then set out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle.
- Ignored input: pulse in_valid with a different data byte during RUN and DONE -> no second result, and the first result is unchanged.
- Round-trip: 256 random data/key pairs through encryption_engine, then through the decryption block -> decrypted data equals the original plaintext for every pair.
